// File: rtl/preg_free_list.sv
// Physical-register free list for rename: a circular FIFO of free pregs with
// multi-lane allocate/release and read-pointer checkpoints for flush recovery.
module preg_free_list #(
    parameter int P_REGISTERS = 64,
    parameter int L_REGISTERS = 32,
    parameter int INSTR_COUNT = 8,
    parameter int CKPT_NUM    = 8,
    parameter int FL_DEPTH    = P_REGISTERS - L_REGISTERS
) (
    input  logic                                             i_clk,
    input  logic                                             i_rst,
    input  logic [INSTR_COUNT-1:0]                           i_alloc_req,
    output logic                                             o_alloc_ready,
    output logic [INSTR_COUNT-1:0][$clog2(P_REGISTERS)-1:0]  o_alloc_preg,
    input  logic [INSTR_COUNT-1:0]                           i_rel_en,
    input  logic [INSTR_COUNT-1:0][$clog2(P_REGISTERS)-1:0]  i_rel_preg,
    input  logic                                             i_ckpt_en,
    input  logic [$clog2(CKPT_NUM)-1:0]                      i_ckpt_id,
    input  logic                                             i_rec_en,
    input  logic [$clog2(CKPT_NUM)-1:0]                      i_rec_ckpt_id,
    output logic [$clog2(FL_DEPTH):0]                        o_free_count,
    output logic                                             o_err_overflow
);

    localparam int PW   = $clog2(P_REGISTERS);
    localparam int IW   = $clog2(FL_DEPTH);
    localparam int PTRW = IW + 1;
    localparam int CW   = $clog2(INSTR_COUNT) + 1;

    // Handshake: the requesting lanes are granted, all together, on any edge
    // where o_alloc_ready is high; releases are accepted unconditionally.

    logic [PW-1:0]   r_fl_mem [FL_DEPTH];
    logic [PTRW-1:0] r_head;
    logic [PTRW-1:0] r_tail;
    logic            r_err;
    logic [PTRW-1:0] r_ckpt [CKPT_NUM];

    logic [CW-1:0]                   w_alloc_cnt;
    logic [CW-1:0]                   w_rel_cnt;
    logic [IW-1:0]                   w_alloc_idx [INSTR_COUNT];
    logic [IW-1:0]                   w_rel_idx [INSTR_COUNT];
    logic [INSTR_COUNT-1:0][PW-1:0]  w_alloc_preg;
    logic [PTRW-1:0]                 w_free;
    logic                            w_alloc_ready;
    logic                            w_rel_ovf;
    logic [PTRW-1:0]                 w_head_nxt;

    // Each lane's slot is the base pointer plus the number of enabled lanes
    // below it, so groups pack densely and wrap through the low index bits.
    always_comb begin
        w_alloc_cnt  = '0;
        w_rel_cnt    = '0;
        w_alloc_preg = '0;
        for (int i = 0; i < INSTR_COUNT; i++) begin
            w_alloc_idx[i] = r_head[IW-1:0] + IW'(w_alloc_cnt);
            w_rel_idx[i]   = r_tail[IW-1:0] + IW'(w_rel_cnt);
            if (i_alloc_req[i]) begin
                w_alloc_preg[i] = r_fl_mem[w_alloc_idx[i]];
            end
            w_alloc_cnt = w_alloc_cnt + CW'(i_alloc_req[i]);
            w_rel_cnt   = w_rel_cnt + CW'(i_rel_en[i]);
        end
    end

    assign w_free        = r_tail - r_head;
    assign w_alloc_ready = (32'(w_alloc_cnt) <= 32'(w_free)) && !i_rec_en;
    assign w_rel_ovf     = (32'(w_free) + 32'(w_rel_cnt)) > 32'(FL_DEPTH);

    always_comb begin
        w_head_nxt = r_head;
        if (i_rec_en) begin
            w_head_nxt = r_ckpt[i_rec_ckpt_id];
        end else if (w_alloc_ready) begin
            w_head_nxt = r_head + PTRW'(w_alloc_cnt);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                r_fl_mem[i] <= PW'(L_REGISTERS + i);
            end
            for (int c = 0; c < CKPT_NUM; c++) begin
                r_ckpt[c] <= '0;
            end
            r_head <= '0;
            r_tail <= PTRW'(FL_DEPTH);
            r_err  <= 1'b0;
        end else begin
            r_head <= w_head_nxt;
            if (w_rel_cnt != '0) begin
                // An over-full release is dropped whole; the error is sticky.
                if (w_rel_ovf) begin
                    r_err <= 1'b1;
                end else begin
                    r_tail <= r_tail + PTRW'(w_rel_cnt);
                    for (int i = 0; i < INSTR_COUNT; i++) begin
                        if (i_rel_en[i]) begin
                            r_fl_mem[w_rel_idx[i]] <= i_rel_preg[i];
                        end
                    end
                end
            end
            if (i_ckpt_en && !i_rec_en) begin
                r_ckpt[i_ckpt_id] <= w_head_nxt;
            end
        end
    end

    assign o_alloc_ready  = w_alloc_ready;
    assign o_alloc_preg   = w_alloc_preg;
    assign o_free_count   = w_free;
    assign o_err_overflow = r_err;

endmodule

// File: tb/tb_preg_free_list.sv
// Bench for preg_free_list: directed scenarios plus a random run, all checked
// against a behavioural free-list model through an expected-value queue.
module tb_preg_free_list;

    logic            clk;
    logic            rst;
    logic [7:0]      alloc_req;
    logic            alloc_ready;
    logic [7:0][5:0] alloc_preg;
    logic [7:0]      rel_en;
    logic [7:0][5:0] rel_preg;
    logic            ckpt_en;
    logic [2:0]      ckpt_id;
    logic            rec_en;
    logic [2:0]      rec_ckpt_id;
    logic [5:0]      free_count;
    logic            err_overflow;

    int checks = 0;
    int errors = 0;

    // Observation / expectation layout: {ready, grants[47:0], free[5:0], err}
    logic [55:0] exp_q[$];
    logic [55:0] obs;
    logic [55:0] exp_v;

    logic [5:0] m_mem [32];
    logic [5:0] m_head;
    logic [5:0] m_tail;
    logic       m_err;
    logic [5:0] m_ck [8];

    preg_free_list dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_alloc_req    (alloc_req),
        .o_alloc_ready  (alloc_ready),
        .o_alloc_preg   (alloc_preg),
        .i_rel_en       (rel_en),
        .i_rel_preg     (rel_preg),
        .i_ckpt_en      (ckpt_en),
        .i_ckpt_id      (ckpt_id),
        .i_rec_en       (rec_en),
        .i_rec_ckpt_id  (rec_ckpt_id),
        .o_free_count   (free_count),
        .o_err_overflow (err_overflow)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = 6'(32 + i);
        for (int c = 0; c < 8; c++) m_ck[c] = 6'd0;
        m_head = 6'd0;
        m_tail = 6'd32;
        m_err  = 1'b0;
    endtask

    task automatic apply_reset();
        alloc_req = '0; rel_en = '0; rel_preg = '0;
        ckpt_en = 1'b0; ckpt_id = '0; rec_en = 1'b0; rec_ckpt_id = '0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [55:0] model_expect();
        logic [5:0]  f;
        logic [47:0] g;
        logic        rdy;
        int          cnt;
        int          k;
        f   = m_tail - m_head;
        g   = '0;
        cnt = $countones(alloc_req);
        rdy = (cnt <= int'(f)) && !rec_en;
        k   = 0;
        for (int i = 0; i < 8; i++) begin
            if (alloc_req[i]) begin
                g[i*6 +: 6] = m_mem[(int'(m_head[4:0]) + k) % 32];
                k++;
            end
        end
        if (!rdy) g = '0;
        return {rdy, g, f, m_err};
    endfunction

    task automatic model_update();
        logic [5:0] f;
        logic [5:0] nh;
        int         cnt;
        int         rc;
        int         k;
        f   = m_tail - m_head;
        cnt = $countones(alloc_req);
        rc  = $countones(rel_en);
        nh  = m_head;
        if (rec_en) nh = m_ck[rec_ckpt_id];
        else if (cnt <= int'(f)) nh = m_head + 6'(cnt);
        if (rc > 0) begin
            if (int'(f) + rc > 32) begin
                m_err = 1'b1;
            end else begin
                k = 0;
                for (int i = 0; i < 8; i++) begin
                    if (rel_en[i]) begin
                        m_mem[(int'(m_tail[4:0]) + k) % 32] = rel_preg[i];
                        k++;
                    end
                end
                m_tail = m_tail + 6'(rc);
            end
        end
        if (ckpt_en && !rec_en) m_ck[ckpt_id] = nh;
        m_head = nh;
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic [7:0] req, input logic [7:0] ren, input logic [47:0] rp,
                         input logic ce, input logic [2:0] cid, input logic re, input logic [2:0] rid);
        @(negedge clk);
        alloc_req = req; rel_en = ren; rel_preg = rp;
        ckpt_en = ce; ckpt_id = cid; rec_en = re; rec_ckpt_id = rid;
        #1;
        exp_q.push_back(model_expect());
        obs = {alloc_ready, (alloc_ready ? alloc_preg : 48'h0), free_count, err_overflow};
        @(posedge clk);
        model_update();
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [47:0] want_g;
        drive(8'hFF, 8'h00, 48'h0, 1'b0, 3'd0, 1'b0, 3'd0);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL reset_pre_alloc got %h expected %h", obs, exp_v);
        end
        // Reset asserted between clock edges must take effect at once.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (free_count !== 6'd32 || err_overflow !== 1'b0) begin
            errors++; $display("FAIL async_reset got free=%0d err=%b expected free=32 err=0", free_count, err_overflow);
        end
        apply_reset();
        drive(8'hFF, 8'h00, 48'h0, 1'b0, 3'd0, 1'b0, 3'd0);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL reset_alloc8 got %h expected %h", obs, exp_v);
        end
        for (int i = 0; i < 8; i++) want_g[i*6 +: 6] = 6'(32 + i);
        checks++;
        if (obs[55] !== 1'b1 || obs[54:7] !== want_g) begin
            errors++; $display("FAIL reset_grants got rdy=%b g=%h expected rdy=1 g=%h", obs[55], obs[54:7], want_g);
        end
        drive(8'h00, 8'h00, 48'h0, 1'b0, 3'd0, 1'b0, 3'd0);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v || obs[6:1] !== 6'd24) begin
            errors++; $display("FAIL reset_free24 got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_sparse();
        logic [47:0] want_g;
        apply_reset();
        drive(8'b1010_0101, 8'h00, 48'h0, 1'b0, 3'd0, 1'b0, 3'd0);
        exp_v = exp_q.pop_front();
        want_g = '0;
        want_g[0*6 +: 6] = 6'd32;
        want_g[2*6 +: 6] = 6'd33;
        want_g[5*6 +: 6] = 6'd34;
        want_g[7*6 +: 6] = 6'd35;
        checks++;
        if (obs !== exp_v || obs[54:7] !== want_g) begin
            errors++; $display("FAIL sparse_grants got %h expected %h grants %h", obs, exp_v, want_g);
        end
        drive(8'h00, 8'h00, 48'h0, 1'b0, 3'd0, 1'b0, 3'd0);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v || obs[6:1] !== 6'd28) begin
            errors++; $display("FAIL sparse_free28 got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_exhaust_wrap();
        logic [47:0] rp;
        apply_reset();
        for (int s = 0; s < 4; s++) begin
            drive(8'hFF, 8'h00, 48'h0, 1'b0, 3'd0, 1'b0, 3'd0);
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL exhaust_step%0d got %h expected %h", s, obs, exp_v);
            end
        end
        drive(8'h01, 8'h00, 48'h0, 1'b0, 3'd0, 1'b0, 3'd0);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v || obs[55] !== 1'b0 || obs[6:1] !== 6'd0) begin
            errors++; $display("FAIL empty_stall got %h expected %h", obs, exp_v);
        end
        rp = '0;
        rp[5:0]  = 6'd5;
        rp[11:6] = 6'd6;
        drive(8'h01, 8'h03, rp, 1'b0, 3'd0, 1'b0, 3'd0);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v || obs[55] !== 1'b0) begin
            errors++; $display("FAIL same_cycle_release got %h expected %h", obs, exp_v);
        end
        drive(8'h01, 8'h00, 48'h0, 1'b0, 3'd0, 1'b0, 3'd0);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v || obs[55] !== 1'b1 || obs[12:7] !== 6'd5 || obs[6:1] !== 6'd2) begin
            errors++; $display("FAIL wrap_regrant got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_checkpoint();
        apply_reset();
        drive(8'h0F, 8'h00, 48'h0, 1'b1, 3'd3, 1'b0, 3'd0);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL ckpt_take got %h expected %h", obs, exp_v);
        end
        drive(8'hFF, 8'h00, 48'h0, 1'b0, 3'd0, 1'b0, 3'd0);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL ckpt_alloc8 got %h expected %h", obs, exp_v);
        end
        // Recovery cycle: request present, must not be granted; checkpoint write ignored.
        drive(8'h01, 8'h00, 48'h0, 1'b1, 3'd3, 1'b1, 3'd3);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v || obs[55] !== 1'b0) begin
            errors++; $display("FAIL rec_no_grant got %h expected %h", obs, exp_v);
        end
        drive(8'h01, 8'h00, 48'h0, 1'b0, 3'd0, 1'b0, 3'd0);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v || obs[6:1] !== 6'd28 || obs[12:7] !== 6'd36) begin
            errors++; $display("FAIL rec_restore got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        drive(8'h00, 8'h01, 48'h9, 1'b0, 3'd0, 1'b0, 3'd0);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL ovf_pre got %h expected %h", obs, exp_v);
        end
        for (int s = 0; s < 3; s++) begin
            drive(8'h00, 8'h00, 48'h0, 1'b0, 3'd0, 1'b0, 3'd0);
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v || obs[0] !== 1'b1 || obs[6:1] !== 6'd32) begin
                errors++; $display("FAIL ovf_sticky%0d got %h expected %h", s, obs, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [47:0] rp;
        logic [7:0]  req;
        logic [7:0]  ren;
        apply_reset();
        for (int s = 0; s < 400; s++) begin
            req = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            ren = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
            for (int i = 0; i < 8; i++) rp[i*6 +: 6] = 6'($urandom_range(0, 63));
            drive(req, ren, rp, ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 15) == 0), 3'($urandom_range(0, 7)));
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL random_step%0d got %h expected %h", s, obs, exp_v);
            end
        end
    endtask

    initial begin
        apply_reset();
        test_reset();
        test_sparse();
        test_exhaust_wrap();
        test_checkpoint();
        test_overflow();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/preg_free_list.md
Name: preg_free_list

Overview:
- Physical-register free list that feeds the rename stage.
- Each cycle it hands out up to INSTR_COUNT free physical registers for new destination mappings. It also takes back up to INSTR_COUNT previous mappings (ppreg) released at commit.
- Circular FIFO with wrap-bit pointers. Per-checkpoint snapshots of the read pointer allow single-cycle recovery on flush.

Parameters:
- P_REGISTERS, 64, number of physical registers.
- L_REGISTERS, 32, number of logical registers. pregs 0..L_REGISTERS-1 are architecturally mapped at reset.
- INSTR_COUNT, 8, allocate and release lanes per cycle.
- CKPT_NUM, 8, number of read-pointer checkpoints.
- FL_DEPTH, P_REGISTERS-L_REGISTERS, FIFO capacity. Must be a power of 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- alloc_req  in  INSTR_COUNT  per-lane allocation request mask.
- alloc_ready  out  1  list holds enough entries for popcount(alloc_req). Combinational.
- alloc_preg  out  INSTR_COUNT x $clog2(P_REGISTERS)  preg granted per lane. Valid only for requesting lanes when alloc_ready=1.
- rel_en  in  INSTR_COUNT  per-lane release strobe.
- rel_preg  in  INSTR_COUNT x $clog2(P_REGISTERS)  preg returned per lane.
- ckpt_en  in  1  take a snapshot of the read pointer.
- ckpt_id  in  $clog2(CKPT_NUM)  snapshot slot to write.
- rec_en  in  1  restore the read pointer from a snapshot (flush).
- rec_ckpt_id  in  $clog2(CKPT_NUM)  snapshot slot to restore.
- free_count  out  $clog2(FL_DEPTH)+1  number of entries currently free.
- err_overflow  out  1  sticky error: a release would exceed FL_DEPTH.

Behaviour:
- Storage: fl_mem[FL_DEPTH].
  - head and tail pointers are $clog2(FL_DEPTH)+1 bits wide; the MSB is the wrap bit.
  - free_count = tail - head, in modulo pointer arithmetic.
- Reset (asynchronous):
  - fl_mem[i] = L_REGISTERS+i.
  - head = 0; tail = FL_DEPTH (wrap bit set, index 0).
  - free_count = FL_DEPTH; err_overflow = 0.
  - All checkpoint slots = 0.
  - alloc_ready = 1 whenever popcount(alloc_req) <= FL_DEPTH.
- Allocation (zero latency, combinational from head):
  - Requesting lanes are ranked by ascending lane index. The k-th requesting lane gets fl_mem[(head+k) mod FL_DEPTH].
  - Non-requesting lanes drive 0.
  - alloc_ready = (popcount(alloc_req) <= free_count) && !rec_en.
  - Grants are all-or-nothing. On the clock edge with alloc_ready=1, head += popcount(alloc_req).
  - alloc_req=0 always gives alloc_ready=1 (unless rec_en) and no pointer change.
- Release:
  - Enabled lanes, in ascending lane order, write rel_preg into fl_mem[tail+k]; tail += popcount(rel_en).
  - Releases are never back-pressured. If free_count + popcount(rel_en) > FL_DEPTH, the write is dropped, tail is held, and err_overflow sets until reset.
- Same-cycle alloc and release:
  - Allocation sees only the pre-edge free_count. Entries released this cycle become allocatable next cycle.
  - Both pointers update on the same edge.
- Checkpoint:
  - On ckpt_en, slot ckpt_id takes the post-edge head, i.e. including any allocation granted in the same cycle.
  - A checkpoint taken in the same cycle as rec_en is ignored.
- Recovery:
  - On rec_en, head <= snapshot[rec_ckpt_id]. No allocation is granted that cycle.
  - Releases in the same cycle still apply to tail.
  - Restored entries are still intact because the tail can never pass head.
  - free_count recomputes from the pointers next cycle.
- Wrap: pointer indexes use the low bits only, so wrap-around is transparent and lane groups may straddle the FIFO boundary.
- Reset mid-operation returns every register to its reset value asynchronously.

Test Plan:
- Reset release, alloc_req=8'hFF -> alloc_ready=1, alloc_preg lanes 0..7 = 32..39; next cycle free_count=24.
- alloc_req=8'b10100101 after reset -> lanes 0,2,5,7 get 32,33,34,35; other lanes 0; free_count=28.
- Four cycles of 8'hFF -> free_count=0. A fifth cycle with alloc_req=8'h01 -> alloc_ready=0; head unchanged.
- From free_count=0: release pregs 5,6 and request 1 lane in the same cycle -> alloc_ready=0. Next cycle alloc_preg[0]=5, and the wrapped index is read correctly.
- ckpt_en ckpt_id=3 with alloc 8'h0F after reset (head 4). Allocate 8 more, then rec_en rec_ckpt_id=3 -> head=4, free_count=28, next alloc_preg[0]=36.
- At free_count=32, release 1 preg -> err_overflow=1 sticky; tail and free_count unchanged.
